// File: rtl/sync_memory.sv
// sync_memory: single-port synchronous RAM. Reset clears it through an init sequencer,
// busy blocks requests, reads are registered with a data_valid strobe.
// Optional `MEM_BOUNDS_CHECK_EN adds an err pulse for accepted accesses with addr >= DEPTH.
module sync_memory #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  read_write,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
`ifdef MEM_BOUNDS_CHECK_EN
  output logic                  err,
`endif
  output logic                  busy
);

  // Index width covers only the implemented words; the address bus may be wider.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [IDX_W-1:0]    idx_t;
  typedef logic [ADDR_WIDTH:0] addr_ext_t;

  localparam idx_t      LAST_IDX  = idx_t'(DEPTH - 1);
  localparam addr_ext_t DEPTH_EXT = addr_ext_t'(DEPTH);

  if (DEPTH < 2 || DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
    $error("sync_memory: DEPTH must lie in 2..2**ADDR_WIDTH");
  end

  typedef enum logic {
    ST_INIT,
    ST_IDLE
  } state_t;

  state_t state_q, state_d;
  idx_t   cnt_q, cnt_d;
  logic   init_we;

  logic                  accept;
  logic                  wr_accept;
  logic                  rd_accept;
  logic                  in_range;
  idx_t                  idx;
  logic [DATA_WIDTH-1:0] rd_data;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Init sequencer
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init_we = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_we = 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + idx_t'(1);
        end
      end
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy = (state_q == ST_INIT);

  // ---------------------------------------------------------------------------
  // Access decode
  // ---------------------------------------------------------------------------
  assign accept    = req & ~busy;
  assign wr_accept = accept & read_write;
  assign rd_accept = accept & ~read_write;

  // Widened compare stays correct when DEPTH == 2**ADDR_WIDTH.
  assign in_range = ({1'b0, addr} < DEPTH_EXT);
  assign idx      = addr[IDX_W-1:0];

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset branch; the init sequencer clears it one word
  // per cycle, which keeps it mappable onto a plain RAM macro.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (init_we) begin
        mem[cnt_q] <= '0;
      end else if (wr_accept && in_range) begin
        mem[idx] <= data_in;
      end
    end
  end

  // Out-of-range reads return zero rather than aliasing onto a real word.
  assign rd_data = in_range ? mem[idx] : '0;

  // ---------------------------------------------------------------------------
  // Registered read port
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= rd_accept;
      if (rd_accept) begin
        data_out <= rd_data;
      end
    end
  end

`ifdef MEM_BOUNDS_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else begin
      err <= accept & ~in_range;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Simulation-only protocol checks
  // ---------------------------------------------------------------------------
`ifndef SYNTHESIS
  a_req_known: assert property (@(posedge clk) disable iff (reset)
    !busy |-> !$isunknown(req));

  a_no_valid_from_busy: assert property (@(posedge clk) disable iff (reset)
    busy |=> !data_valid);

  a_read_latency: assert property (@(posedge clk) disable iff (reset)
    rd_accept |=> data_valid);

  a_write_no_valid: assert property (@(posedge clk) disable iff (reset)
    (wr_accept || !accept) |=> !data_valid);
`endif

endmodule
